// File: rtl/mac_operand_loader_pkg.sv
// Shared defaults and FSM state type for the MAC operand loader.
package mac_operand_loader_pkg;

    localparam int DEF_IN_WIDTH     = 16;
    localparam int DEF_OUTPUT_WIDTH = 32;
    localparam int DEF_N_TAPS       = 36;
    localparam int DEF_MAC_LATENCY  = 3;

    typedef enum logic [1:0] {
        LOAD_K = 2'd0,
        LOAD_I = 2'd1,
        FIRE   = 2'd2
    } state_t;

endpackage

// File: rtl/mac_valid_delay.sv
// Issue-valid delay line: vld_out is vld_in delayed by LATENCY clock edges.
module mac_valid_delay
    import mac_operand_loader_pkg::*;
#(
    parameter int LATENCY = DEF_MAC_LATENCY
) (
    input  logic clk,
    input  logic arst_n_in,
    input  logic vld_in,
    output logic vld_out
);

    logic [LATENCY-1:0] vld_pipe;

    // Shift register of issue strobes; reset flushes any in-flight issue.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= vld_in;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign vld_out = vld_pipe[LATENCY-1];

endmodule

// File: rtl/mac_operand_loader.sv
// Streams kernel and activation windows into operand registers for a
// downstream MAC array, issues one window at a time and captures the result.
// Optional feature: define KERNEL_REUSE_EN to keep the loaded kernel across
// windows unless kernel_reload_in is high on the issuing cycle.
module mac_operand_loader
    import mac_operand_loader_pkg::*;
#(
    parameter int IN_WIDTH     = DEF_IN_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int N_TAPS       = DEF_N_TAPS,
    parameter int MAC_LATENCY  = DEF_MAC_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 arst_n_in,
    input  logic signed [IN_WIDTH-1:0]           data_in,
    input  logic                                 data_valid_in,
    output logic                                 data_ready_out,
    input  logic                                 kernel_reload_in,
    output logic [N_TAPS-1:0][IN_WIDTH-1:0]      I_out,
    output logic [N_TAPS-1:0][IN_WIDTH-1:0]      K_out,
    input  logic signed [OUTPUT_WIDTH-1:0]       mac_result_in,
    output logic signed [OUTPUT_WIDTH-1:0]       result_out,
    output logic                                 result_valid_out,
    input  logic                                 result_ready_in,
    output logic                                 issue_out
);

    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TAPS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             last_word;
    logic             inflight;
    logic             mac_done;

    assign xfer      = data_valid_in && data_ready_out;
    assign last_word = (cnt == LAST_IDX);

`ifndef KERNEL_REUSE_EN
    // Without kernel reuse every window reloads the kernel; the hint is unused.
    logic unused_kernel_reload;
    assign unused_kernel_reload = kernel_reload_in;
`endif

    // State register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) state <= LOAD_K;
        else            state <= state_n;
    end

    // Next state, ready and issue strobe. Issue waits until the single result
    // slot (in flight or buffered) is free.
    always_comb begin
        state_n        = state;
        data_ready_out = 1'b0;
        issue_out      = 1'b0;
        case (state)
            LOAD_K: begin
                data_ready_out = 1'b1;
                if (data_valid_in && last_word) state_n = LOAD_I;
            end
            LOAD_I: begin
                data_ready_out = 1'b1;
                if (data_valid_in && last_word) state_n = FIRE;
            end
            FIRE: begin
                if (!result_valid_out && !inflight) begin
                    issue_out = 1'b1;
`ifdef KERNEL_REUSE_EN
                    state_n = kernel_reload_in ? LOAD_K : LOAD_I;
`else
                    state_n = LOAD_K;
`endif
                end
            end
            default: state_n = LOAD_K;
        endcase
    end

    // Word counter within the current load phase; wraps to 0 after the last tap.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)    cnt <= '0;
        else if (xfer)     cnt <= last_word ? '0 : cnt + 1'b1;
    end

    // Operand registers: each accepted word lands in the tap selected by cnt.
    // No writes happen in FIRE, so the window is stable through issue.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            I_out <= '0;
            K_out <= '0;
        end else if (xfer) begin
            for (int n = 0; n < N_TAPS; n++) begin
                if (cnt == CNT_W'(n)) begin
                    if (state == LOAD_K) K_out[n] <= data_in;
                    else                 I_out[n] <= data_in;
                end
            end
        end
    end

    mac_valid_delay #(
        .LATENCY (MAC_LATENCY)
    ) u_valid_delay (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .vld_in    (issue_out),
        .vld_out   (mac_done)
    );

    // Tracks the one issued window whose result has not yet arrived.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)     inflight <= 1'b0;
        else if (issue_out) inflight <= 1'b1;
        else if (mac_done)  inflight <= 1'b0;
    end

    // Result buffer: capture the MAC sum as-is, hold until the consumer takes it.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            result_out       <= '0;
            result_valid_out <= 1'b0;
        end else if (mac_done) begin
            result_out       <= mac_result_in;
            result_valid_out <= 1'b1;
        end else if (result_ready_in) begin
            result_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader; the bench acts as the downstream
// MAC array (fixed-latency dot product of the issued window).
module tb_mac_operand_loader;

    localparam int W  = 16;
    localparam int OW = 32;
    localparam int NT = 36;
    localparam int L  = 3;

    logic                    clk;
    logic                    arst_n_in;
    logic signed [W-1:0]     data_in;
    logic                    data_valid_in;
    logic                    data_ready_out;
    logic                    kernel_reload_in;
    logic [NT-1:0][W-1:0]    I_out;
    logic [NT-1:0][W-1:0]    K_out;
    logic signed [OW-1:0]    mac_result_in;
    logic signed [OW-1:0]    result_out;
    logic                    result_valid_out;
    logic                    result_ready_in;
    logic                    issue_out;

    int checks   = 0;
    int failures = 0;

    mac_operand_loader #(
        .IN_WIDTH     (W),
        .OUTPUT_WIDTH (OW),
        .N_TAPS       (NT),
        .MAC_LATENCY  (L)
    ) dut (
        .clk              (clk),
        .arst_n_in        (arst_n_in),
        .data_in          (data_in),
        .data_valid_in    (data_valid_in),
        .data_ready_out   (data_ready_out),
        .kernel_reload_in (kernel_reload_in),
        .I_out            (I_out),
        .K_out            (K_out),
        .mac_result_in    (mac_result_in),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready_in),
        .issue_out        (issue_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC array model: sum is valid on mac_result_in only during cycle T+L.
    function automatic logic signed [OW-1:0] dot(input logic [NT-1:0][W-1:0] a,
                                                 input logic [NT-1:0][W-1:0] b);
        logic signed [OW-1:0] s;
        s = '0;
        for (int n = 0; n < NT; n++) s = s + $signed(a[n]) * $signed(b[n]);
        return s;
    endfunction

    logic [L:1]           pv = '0;
    logic signed [OW-1:0] pd [1:L];

    always @(posedge clk) begin
        pv[1] <= issue_out;
        pd[1] <= dot(I_out, K_out);
        for (int i = 2; i <= L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mac_result_in = pv[L] ? pd[L] : 32'shDEADBEEF;

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic send_word(input logic signed [W-1:0] w);
        int t;
        t = 0;
        data_in       = w;
        data_valid_in = 1'b1;
        while (!data_ready_out && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        data_valid_in = 1'b0;
    endtask

    task automatic send_const(input logic signed [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) send_word(v);
    endtask

    task automatic send_ramp(input int n);
        for (int i = 0; i < n; i++) send_word(W'(i));
    endtask

    task automatic wait_issue(output bit ok);
        int t;
        t = 0;
        while (!issue_out && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = issue_out;
    endtask

    task automatic wait_result(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!result_valid_out && k < 50);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst_n_in = 1'b0; data_in = '0; data_valid_in = 1'b0;
        kernel_reload_in = 1'b1; result_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (I_out !== '0 || K_out !== '0) begin
            failures++; $display("FAIL reset_operands got nonzero want 0");
        end
        checks++;
        if (result_out !== '0 || result_valid_out !== 1'b0) begin
            failures++; $display("FAIL reset_result got=%0d/%0b want 0/0", result_out, result_valid_out);
        end
        checks++;
        if (issue_out !== 1'b0) begin
            failures++; $display("FAIL reset_issue got=%0b want 0", issue_out);
        end
        arst_n_in = 1'b1;
        #1;
        checks++;
        if (data_ready_out !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%0b want 1", data_ready_out);
        end
        @(negedge clk);
    endtask

    task automatic test_ones();
        bit ok; int k;
        result_ready_in = 1'b1; kernel_reload_in = 1'b1;
        send_const(16'sd1, NT);
        send_const(16'sd1, NT);
        wait_issue(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ones_issue got=0 want=1"); end
        checks++;
        if (data_ready_out !== 1'b0) begin
            failures++; $display("FAIL ones_ready_in_fire got=%0b want=0", data_ready_out);
        end
        checks++;
        if ($signed(K_out[0]) !== 16'sd1 || $signed(I_out[NT-1]) !== 16'sd1) begin
            failures++; $display("FAIL ones_window got K0=%0d I35=%0d want 1/1", $signed(K_out[0]), $signed(I_out[NT-1]));
        end
        @(negedge clk);
        checks++;
        if (issue_out !== 1'b0) begin
            failures++; $display("FAIL ones_issue_pulse got=%0b want=0", issue_out);
        end
        wait_result(k);
        checks++;
        if (k + 1 != L + 1) begin
            failures++; $display("FAIL ones_latency got=%0d want=%0d", k + 1, L + 1);
        end
        checks++;
        if (result_out !== 32'sd36) begin
            failures++; $display("FAIL ones_result got=%0d want=36", result_out);
        end
        @(negedge clk);
        checks++;
        if (result_valid_out !== 1'b0) begin
            failures++; $display("FAIL ones_valid_one_cycle got=%0b want=0", result_valid_out);
        end
    endtask

    task automatic test_ramp();
        bit ok; int k;
        send_const(16'sd1, NT);
        send_ramp(NT);
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_out !== 32'sd630) begin
            failures++; $display("FAIL ramp_result got=%0d want=630", result_out);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok; int k;
        send_const(-16'sd32768, NT);
        send_const(-16'sd32768, NT);
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_valid_out !== 1'b1 || result_out !== 32'sd0) begin
            failures++; $display("FAIL wrap_result got=%0d valid=%0b want=0 valid=1", result_out, result_valid_out);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok, stall_ok; int k;
        result_ready_in = 1'b0;
        send_const(16'sd1, NT);
        send_const(16'sd1, NT);
        wait_issue(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_first_issue got=0 want=1"); end
        send_const(16'sd1, NT);
        send_ramp(NT);
        stall_ok = 1'b1;
        repeat (4) begin
            if (data_ready_out !== 1'b0 || issue_out !== 1'b0) stall_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stall_ok) begin failures++; $display("FAIL bp_stall got ready/issue high want both 0"); end
        checks++;
        if (result_valid_out !== 1'b1 || result_out !== 32'sd36) begin
            failures++; $display("FAIL bp_held_result got=%0d valid=%0b want=36 valid=1", result_out, result_valid_out);
        end
        result_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (result_valid_out !== 1'b0) begin
            failures++; $display("FAIL bp_consume got=%0b want=0", result_valid_out);
        end
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_out !== 32'sd630) begin
            failures++; $display("FAIL bp_second_result got=%0d want=630", result_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midload();
        bit ok, kok; int k;
        result_ready_in = 1'b1; kernel_reload_in = 1'b1;
        send_const(16'sd3, NT);
        send_const(16'sd5, 17);
        arst_n_in = 1'b0;
        #1;
        checks++;
        if (I_out !== '0 || K_out !== '0) begin
            failures++; $display("FAIL midload_operands got nonzero want 0");
        end
        checks++;
        if (result_out !== '0 || result_valid_out !== 1'b0 || issue_out !== 1'b0) begin
            failures++; $display("FAIL midload_outputs got=%0d/%0b/%0b want 0/0/0", result_out, result_valid_out, issue_out);
        end
        @(negedge clk);
        arst_n_in = 1'b1;
        #1;
        checks++;
        if (data_ready_out !== 1'b1) begin
            failures++; $display("FAIL midload_ready got=%0b want=1", data_ready_out);
        end
        send_const(16'sd7, NT);
        kok = 1'b1;
        for (int n = 0; n < NT; n++) if ($signed(K_out[n]) !== 16'sd7) kok = 1'b0;
        checks++;
        if (!kok || I_out !== '0) begin
            failures++; $display("FAIL midload_k_landing got K0=%0d I0=%0d want 7/0", $signed(K_out[0]), $signed(I_out[0]));
        end
        send_const(16'sd2, NT);
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_out !== 32'sd504) begin
            failures++; $display("FAIL midload_result got=%0d want=504", result_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        bit ok, seen;
        send_const(16'sd1, NT);
        send_const(16'sd1, NT);
        wait_issue(ok);
        @(negedge clk);
        arst_n_in = 1'b0;
        @(negedge clk);
        arst_n_in = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (result_valid_out !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (!ok || seen) begin
            failures++; $display("FAIL inflight_discard got valid=%0b want=0", seen);
        end
    endtask

    task automatic test_kernel_select();
        bit ok; int k;
        result_ready_in = 1'b1; kernel_reload_in = 1'b0;
        send_const(16'sd2, NT);
        send_const(16'sd1, NT);
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_out !== 32'sd72) begin
            failures++; $display("FAIL kern_first got=%0d want=72", result_out);
        end
`ifdef KERNEL_REUSE_EN
        send_const(-16'sd1, NT);
        checks++;
        if (data_ready_out !== 1'b0 || $signed(K_out[0]) !== 16'sd2) begin
            failures++; $display("FAIL kern_reuse_state got ready=%0b K0=%0d want 0/2", data_ready_out, $signed(K_out[0]));
        end
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_out !== -32'sd72) begin
            failures++; $display("FAIL kern_reuse_result got=%0d want=-72", result_out);
        end
`else
        send_const(16'sd3, NT);
        checks++;
        if ($signed(K_out[NT-1]) !== 16'sd3 || data_ready_out !== 1'b1) begin
            failures++; $display("FAIL kern_reload_forced got K35=%0d ready=%0b want 3/1", $signed(K_out[NT-1]), data_ready_out);
        end
        send_const(16'sd1, NT);
        wait_issue(ok);
        wait_result(k);
        checks++;
        if (!ok || result_out !== 32'sd108) begin
            failures++; $display("FAIL kern_reload_result got=%0d want=108", result_out);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_wrap();
        test_backpressure();
        test_reset_midload();
        test_reset_inflight();
        test_kernel_select();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
